// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
// Widths, reset address default, FSM states and buffer entry layout.
package cpu_pkg;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] op;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] pc_next(
        input logic [ADDR_W-1:0] pc
    );
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, opcode} entries.
// Push, pop and a synchronous flush that empties it in one cycle.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding imem requests into a prefetch buffer.
// Define FETCH_STATS_EN to add the fetch_count / flush_count statistics outputs.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_data,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [7:0]        flush_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              idle_q;

    logic              push, pop;
    logic [CW-1:0]     count;
    logic [CW:0]       post_cnt;
    fetch_entry_t      head;
    fetch_entry_t      push_data;

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.op;
    assign instr_pc    = head.pc;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push_data   = '{pc: fetch_pc_q, op: imem_data};
    assign post_cnt    = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    // idle_q delays halted by one cycle after the FSM settles in IDLE
    assign halted = halt & idle_q & (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (!halt && count < CW'(DEPTH)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (imem_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_next(fetch_pc_q);
                    if (!halt && post_cnt < (CW+1)'(DEPTH)) begin
                        addr_d = pc_next(fetch_pc_q);
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            idle_q     <= (state_q == IDLE);
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (pop && fetch_count != '1) begin
                fetch_count <= fetch_count + 1'b1;
            end
            if (redirect && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the prefetch buffer entry count (legal 2..4).
REQ-002 Parameter RESET_PC, default 8'h00, SHALL be the first fetch address after reset.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 imem_req  out  1  SHALL mean a fetch request is outstanding.
REQ-006 imem_addr  out  8  SHALL carry the fetch address.
REQ-007 imem_ack  in  1  SHALL mark imem_data valid and complete the request.
REQ-008 imem_data  in  8  SHALL carry the instruction byte.
REQ-009 instr_valid  out  1  SHALL mean the buffer head is valid.
REQ-010 instr  out  8  SHALL carry the head opcode to the controller.
REQ-011 instr_pc  out  8  SHALL carry the head instruction's address.
REQ-012 instr_ready  in  1  SHALL mean the controller consumes the head this cycle.
REQ-013 redirect  in  1  SHALL mean a taken jump; it flushes the buffer and refetches.
REQ-014 redirect_pc  in  8  SHALL carry the jump target, sampled when redirect=1.
REQ-015 halt  in  1  SHALL block new requests while high (level).
REQ-016 halted  out  1  SHALL mean halt=1 and no request is outstanding.

Function
REQ-017 FSM states SHALL be IDLE, REQ and DRAIN.
REQ-018 IDLE SHALL go to REQ when halt=0, redirect=0 and count<DEPTH; imem_req=1 and imem_addr=fetch_pc SHALL be registered on that edge.
REQ-019 imem_req and imem_addr SHALL stay stable in REQ until imem_ack=1.
REQ-020 REQ with ack:
- push {fetch_pc, imem_data}
- fetch_pc+1, wrapping 8'hFF->8'h00
- stay in REQ with the new address if post-push count<DEPTH and halt=0, else go to IDLE.
REQ-021 At most one request SHALL be outstanding, and a slot SHALL be free for it whenever one is issued, so a push never overflows.
REQ-022 instr_valid SHALL equal (count!=0); instr/instr_pc SHALL be driven from registered buffer contents.
REQ-023 Pop SHALL occur when instr_valid and instr_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 Redirect SHALL override push and pop:
- count<=0
- fetch_pc<=redirect_pc
- instr_valid=0 on the next cycle.
REQ-025 Redirect in REQ without ack SHALL go to DRAIN; DRAIN SHALL hold imem_req until ack, discard the data, then go to IDLE.
REQ-026 Redirect with ack in the same cycle SHALL discard the data and go to IDLE; redirect in IDLE or DRAIN SHALL only update fetch_pc and flush.
REQ-027 Latency SHALL be: request one edge after leaving IDLE; instr_valid one edge after ack.
REQ-028 Halt asserted in REQ SHALL let the outstanding fetch complete and push; halted SHALL rise the cycle after the FSM reaches IDLE.

Reset
REQ-029 While reset=0, outputs SHALL be:
- imem_req=0, imem_addr=RESET_PC
- instr_valid=0, instr=0, instr_pc=0
- halted=0.
REQ-030 While reset=0, internal state SHALL be: fetch_pc=RESET_PC, count=0, FSM=IDLE.
REQ-031 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset release in IDLE SHALL be ignored.

Configuration
REQ-032 With FETCH_STATS_EN defined, the block SHALL add output fetch_count (16 bits, reset 0, +1 per pop, saturating at 16'hFFFF) and output flush_count (8 bits, reset 0, +1 per redirect, saturating at 8'hFF).
REQ-033 Without FETCH_STATS_EN, neither port nor its counters SHALL exist.

Structure
REQ-034 Shared package cpu_pkg SHALL hold: the fetch state enum, WORD_W=8, ADDR_W=8, RESET_PC default.
REQ-035 The buffer SHALL be sub-module fetch_buffer: a DEPTH-entry FIFO with push, pop and synchronous flush.

Verification
REQ-036 The bench SHALL cover each of the following directed scenarios:
- Reset release, ack same cycle as req, instr_ready=1 -> instr_pc 00,01,02 on consecutive cycles.
- instr_ready=0, ack always high -> exactly 2 entries (00,01) buffered, imem_req low, FSM IDLE.
- Redirect to 8'h40 while a request to 03 is pending and ack delayed 3 cycles -> DRAIN, 03 data dropped, next instr_pc=40.
- fetch_pc=8'hFF, ack -> instr_pc=FF, then next imem_addr=00.
- halt=1 mid-request, ack after 2 cycles -> entry pushed, halted=1 one cycle later, no new req until halt=0.
- Reset low during REQ with FETCH_STATS_EN -> imem_req=0 and fetch_count=0 immediately.
